piso16_tx: RTL and testbench

PISO16_TX -- requirements
Module: piso16_tx

---
 rtl/piso16_tx_if.sv | 23 ++
 rtl/piso16_tx.sv | 111 +++++++++++
 tb/tb_piso16_tx.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/piso16_tx_if.sv
// Load handshake and serial output bundle for piso16_tx.
// The master drives words in; the slave (the transmitter) drives the serial side.
interface piso16_tx_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             out;
  logic             out_valid;
  logic             piso_done;
  logic             busy;

  modport master (
    output data_in, load_valid,
    input  load_ready, out, out_valid, piso_done, busy
  );

  modport slave (
    input  data_in, load_valid,
    output load_ready, out, out_valid, piso_done, busy
  );
endinterface

// File: rtl/piso16_tx.sv
// piso16_tx: parallel-in serial-out transmitter with a valid/ready load port.
// Defining PISO_SKID_EN adds a one-word holding buffer so back-to-back words stream with no gap.
module piso16_tx #(
  parameter int WIDTH     = 16,
  parameter bit LSB_FIRST = 1'b0
) (
  input logic        clk,
  input logic        rst_n,
  piso16_tx_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [4:0] LAST = 5'(WIDTH - 1);

  state_t           state, state_next;
  logic [4:0]       cnt, cnt_next;
  logic [WIDTH-1:0] shreg, shreg_next, shifted;
  logic             accept, last_bit;
`ifdef PISO_SKID_EN
  logic [WIDTH-1:0] hold, hold_next;
  logic             full, full_next;
`endif

  assign last_bit = (state == SHIFT) && (cnt == LAST);
  assign shifted  = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
  assign accept   = bus.load_valid & bus.load_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
`ifdef PISO_SKID_EN
      hold  <= '0;
      full  <= 1'b0;
`endif
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      shreg <= shreg_next;
`ifdef PISO_SKID_EN
      hold  <= hold_next;
      full  <= full_next;
`endif
    end
  end

  // On the last-bit edge a pending word (buffered or arriving now) starts immediately.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shreg_next = shreg;
`ifdef PISO_SKID_EN
    hold_next  = hold;
    full_next  = full;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          shreg_next = bus.data_in;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shreg_next = shifted;
        cnt_next   = cnt + 5'd1;
        if (last_bit) begin
          cnt_next = '0;
`ifdef PISO_SKID_EN
          if (full) begin
            shreg_next = hold;
            full_next  = 1'b0;
          end else if (accept) begin
            shreg_next = bus.data_in;
          end else begin
            state_next = IDLE;
          end
`else
          state_next = IDLE;
`endif
        end
`ifdef PISO_SKID_EN
        else if (accept) begin
          hold_next = bus.data_in;
          full_next = 1'b1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.out       = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.piso_done = 1'b0;
`ifdef PISO_SKID_EN
    bus.load_ready = ~full;
`else
    bus.load_ready = (state == IDLE);
`endif
    if (state == SHIFT) begin
      bus.out       = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
      bus.out_valid = 1'b1;
      bus.busy      = 1'b1;
      bus.piso_done = (cnt == LAST);
    end
  end
endmodule

// File: tb/tb_piso16_tx.sv
// Bench for piso16_tx: MSB-first and LSB-first instances share one source and are
// checked every cycle against a timeline computed from accept/start edges of each word.
module tb_piso16_tx;
  localparam int W = 16;
`ifdef PISO_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_valid;
  logic [W-1:0] data_in;
  int           vectors = 0;
  int           miscompares = 0;

  logic [W-1:0] w [8];
  int           g [8];
  int           p [8];
  int           a [8];
  int           s [8];
  int           n;

  always #5 clk = ~clk;

  piso16_tx_if #(.WIDTH(W)) bus_msb ();
  piso16_tx_if #(.WIDTH(W)) bus_lsb ();

  assign bus_msb.load_valid = load_valid;
  assign bus_msb.data_in    = data_in;
  assign bus_lsb.load_valid = load_valid;
  assign bus_lsb.data_in    = data_in;

  piso16_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (.clk(clk), .rst_n(rst_n), .bus(bus_msb.slave));
  piso16_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (.clk(clk), .rst_n(rst_n), .bus(bus_lsb.slave));

  task automatic check_output(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, " msb out"},   bus_msb.out,        1'b0);
    check_output({tag, " msb valid"}, bus_msb.out_valid,  1'b0);
    check_output({tag, " msb done"},  bus_msb.piso_done,  1'b0);
    check_output({tag, " msb busy"},  bus_msb.busy,       1'b0);
    check_output({tag, " msb ready"}, bus_msb.load_ready, 1'b1);
    check_output({tag, " lsb out"},   bus_lsb.out,        1'b0);
    check_output({tag, " lsb valid"}, bus_lsb.out_valid,  1'b0);
    check_output({tag, " lsb done"},  bus_lsb.piso_done,  1'b0);
    check_output({tag, " lsb busy"},  bus_lsb.busy,       1'b0);
    check_output({tag, " lsb ready"}, bus_lsb.load_ready, 1'b1);
  endtask

  // Word j is offered from edge p[j] until its accept edge a[j]; data is random otherwise.
  task automatic apply_stimulus(input int t);
    load_valid = 1'b0;
    data_in    = W'($urandom);
    for (int j = 0; j < n; j++) begin
      if (p[j] <= t + 1 && t + 1 <= a[j]) begin
        load_valid = 1'b1;
        data_in    = w[j];
      end
    end
  endtask

  task automatic check_cycle(input int t);
    logic ev, ed, eb_msb, eb_lsb, pending, er;
    int   i;
    ev = 1'b0; ed = 1'b0; eb_msb = 1'b0; eb_lsb = 1'b0; pending = 1'b0;
    for (int j = 0; j < n; j++) begin
      if (t >= s[j] && t < s[j] + W) begin
        i      = t - s[j];
        ev     = 1'b1;
        eb_msb = w[j][W-1-i];
        eb_lsb = w[j][i];
        ed     = (i == W - 1);
      end
      if (t >= a[j] && t < s[j]) pending = 1'b1;
    end
    er = SKID ? ~pending : ~ev;
    check_output($sformatf("c%0d msb out", t),   bus_msb.out,        eb_msb);
    check_output($sformatf("c%0d msb valid", t), bus_msb.out_valid,  ev);
    check_output($sformatf("c%0d msb done", t),  bus_msb.piso_done,  ed);
    check_output($sformatf("c%0d msb busy", t),  bus_msb.busy,       ev);
    check_output($sformatf("c%0d msb ready", t), bus_msb.load_ready, er);
    check_output($sformatf("c%0d lsb out", t),   bus_lsb.out,        eb_lsb);
    check_output($sformatf("c%0d lsb valid", t), bus_lsb.out_valid,  ev);
    check_output($sformatf("c%0d lsb done", t),  bus_lsb.piso_done,  ed);
    check_output($sformatf("c%0d lsb busy", t),  bus_lsb.busy,       ev);
    check_output($sformatf("c%0d lsb ready", t), bus_lsb.load_ready, er);
  endtask

  // Edge 0 is the edge just passed; a word occupies the W cycles following its start edge s[j].
  task automatic run_schedule(input int abort_bit);
    int earliest, t_end;
    for (int j = 0; j < n; j++) begin
      earliest = (j == 0) ? 1 : (SKID ? s[j-1] + 1 : s[j-1] + W + 1);
      p[j]     = ((j == 0) ? 1 : a[j-1] + 1) + g[j];
      a[j]     = (p[j] > earliest) ? p[j] : earliest;
      s[j]     = (j == 0) ? a[j] : ((a[j] > s[j-1] + W) ? a[j] : s[j-1] + W);
    end
    t_end = s[n-1] + W;
    for (int t = 0; t <= t_end; t++) begin
      apply_stimulus(t);
      if (abort_bit >= 0 && t == s[0] + abort_bit) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs($sformatf("abort c%0d", t));
        load_valid = 1'b0;
        return;
      end
      @(negedge clk);
      check_cycle(t);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    data_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    $display("[TB] single words A5C3 and 0001");
    rst_n = 1'b1;
    n = 1; w[0] = 16'hA5C3; g[0] = 0;
    run_schedule(-1);
    n = 1; w[0] = 16'h0001; g[0] = 2;
    run_schedule(-1);

    $display("[TB] back-to-back FFFF then 0000");
    n = 2; w[0] = 16'hFFFF; w[1] = 16'h0000; g[0] = 0; g[1] = 0;
    run_schedule(-1);

    $display("[TB] reset at bit 7 of 1234, then BEEF");
    n = 1; w[0] = 16'h1234; g[0] = 0;
    run_schedule(7);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("held");
    rst_n = 1'b1;
    n = 1; w[0] = 16'hBEEF; g[0] = 0;
    run_schedule(-1);

    $display("[TB] random word streams");
    for (int b = 0; b < 6; b++) begin
      n = $urandom_range(2, 8);
      for (int j = 0; j < n; j++) begin
        w[j] = W'($urandom);
        g[j] = (b < 4) ? $urandom_range(0, 3) : $urandom_range(0, 20);
      end
      run_schedule(-1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
